// File: rtl/alu_pkg.sv
// Shared types and constants for the registered ALU execute stage.
// Opcode encoding, FSM states and small opcode-decoding helpers.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  localparam logic [SHW-1:0] SHAMT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0] SHAMT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_NOR = 4'b1100
  } alu_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB,
      ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_NOR: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_serial_shifter.sv
// One-bit-per-cycle shifter: latches operand, amount and direction at start,
// and flags the cycle whose shifted value is the final result.
module serial_shifter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             done_o,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] shreg_q, shreg_d, shifted_s;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             arith_q, arith_d;

  // One-bit step in the latched direction, with sign fill for arithmetic right.
  always_comb begin
    shifted_s = shreg_q;
    if (left_q) begin
      shifted_s = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted_s = {arith_q & shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
    end
  end

  // Load on start, otherwise step until the count runs out.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;
    if (start_i) begin
      shreg_d = a_i;
      cnt_d   = shamt_i;
      left_d  = (op_i == ALU_SLL);
      arith_d = (op_i == ALU_SRA);
    end else if (cnt_q != SHAMT_ZERO) begin
      shreg_d = shifted_s;
      cnt_d   = cnt_q - SHAMT_ONE;
    end else begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= SHAMT_ZERO;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

  assign done_o  = (cnt_q == SHAMT_ONE);
  assign value_o = shifted_s;

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute stage: single-cycle logic/arithmetic ops plus a serial
// shifter, with a valid/ready handshake on both sides.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);
  import alu_pkg::*;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] alu_s;
  logic [WIDTH-1:0] sh_value_s;
  logic             sh_done_s;
  logic             sh_start_s;
  logic             accept_s;
  logic [SHW-1:0]   shamt_s;

  assign shamt_s  = b[SHW-1:0];
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;

  // Single-cycle function-unit select; a zero-amount shift passes A through.
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (op)
      ALU_AND: alu_s = a & b;
      ALU_OR:  alu_s = a | b;
      ALU_ADD: alu_s = a + b;
      ALU_XOR: alu_s = a ^ b;
      ALU_SUB: alu_s = a - b;
      ALU_SLT: alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_s = a;
      ALU_NOR: alu_s = ~(a | b);
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and result-register update.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    sh_start_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (is_shift_op(op) && (shamt_s != {SHW{1'b0}})) begin
            sh_start_s  = 1'b1;
            out_valid_d = 1'b0;
            state_d     = SHIFT;
          end else begin
            result_d    = alu_s;
            zero_d      = (alu_s == {WIDTH{1'b0}});
            illegal_d   = !is_legal_op(op);
            out_valid_d = 1'b1;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      SHIFT: begin
        if (sh_done_s) begin
          result_d    = sh_value_s;
          zero_d      = (sh_value_s == {WIDTH{1'b0}});
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  serial_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (sh_start_s),
    .op_i    (op),
    .a_i     (a),
    .shamt_i (shamt_s),
    .done_o  (sh_done_s),
    .value_o (sh_value_s)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op at a negedge, require it to be accepted at the next posedge,
  // then scramble the inputs so late changes would be visible.
  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    check_eq("send_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'b0010;
    a  = 32'hDEAD_BEEF;
    b  = 32'h1234_5677;
  endtask

  task automatic expect_single(input string tag, input logic [31:0] r, input logic z, input logic il);
    @(negedge clk);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_result"}, result, r);
    check_eq({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
    check_eq({tag, "_illegal"}, {31'd0, illegal}, {31'd0, il});
  endtask

  // Wait for a shift result; returns cycles spent with out_valid low and
  // the number of those cycles where in_ready was wrongly high.
  task automatic wait_shift(output int n, output int rdy_hi);
    n = 0;
    rdy_hi = 0;
    @(negedge clk);
    while (out_valid == 1'b0 && n < 100) begin
      if (in_ready) rdy_hi++;
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int bad;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 4'b0000;
    a = 32'd0;
    b = 32'd0;

    @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_zero", {31'd0, zero}, 32'd1);
    check_eq("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(4'b0001, 32'h0000_F0F0, 32'h0F0F_0000);
    expect_single("or", 32'h0F0F_F0F0, 1'b0, 1'b0);

    send(4'b0110, 32'd5, 32'd5);
    expect_single("sub", 32'd0, 1'b1, 1'b0);
    send(4'b0111, 32'hFFFF_FFFF, 32'd1);
    expect_single("slt", 32'd1, 1'b0, 1'b0);
    send(4'b0111, 32'd1, 32'hFFFF_FFFF);
    expect_single("slt_neg", 32'd0, 1'b1, 1'b0);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1);
    expect_single("add_wrap", 32'd0, 1'b1, 1'b0);
    send(4'b1100, 32'h0000_00FF, 32'hF000_0000);
    expect_single("nor", 32'h0FFF_FF00, 1'b0, 1'b0);

    // Back-to-back single-cycle ops: one accept per clock.
    send(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0);
    check_eq("b2b_and", result, 32'h0F00_0F00);
    send(4'b0011, 32'hFF00_FF00, 32'h0FF0_0FF0);
    check_eq("b2b_xor", result, 32'hF0F0_F0F0);

    send(4'b1010, 32'h8000_0000, 32'd31);
    wait_shift(n, bad);
    check_eq("sra_cycles", n, 32'd31);
    check_eq("sra_busy_ready", bad, 32'd0);
    check_eq("sra_result", result, 32'hFFFF_FFFF);

    send(4'b1001, 32'h8000_0000, 32'hFFFF_FFE4);
    wait_shift(n, bad);
    check_eq("srl_cycles", n, 32'd4);
    check_eq("srl_result", result, 32'h0800_0000);

    send(4'b1000, 32'h0000_0001, 32'd3);
    wait_shift(n, bad);
    check_eq("sll_cycles", n, 32'd3);
    check_eq("sll_result", result, 32'h0000_0008);

    send(4'b1000, 32'h1234_5678, 32'h0000_0020);
    expect_single("sll_zero_amt", 32'h1234_5678, 1'b0, 1'b0);

    // Back-pressure: result must sit still while writeback stalls.
    send(4'b0010, 32'd1, 32'd2);
    out_ready = 1'b0;
    expect_single("bp_add", 32'd3, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result !== 32'd3 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check_eq("bp_hold", bad, 32'd0);
    out_ready = 1'b1;
    send(4'b0011, 32'hFF00_FF00, 32'h0FF0_0FF0);
    expect_single("bp_xor", 32'hF0F0_F0F0, 1'b0, 1'b0);

    send(4'b0100, 32'd5, 32'd3);
    expect_single("illegal", 32'd0, 1'b1, 1'b1);
    check_eq("illegal_no_shift", {31'd0, in_ready}, 32'd1);
    send(4'b1011, 32'd7, 32'd9);
    expect_single("illegal_1011", 32'd0, 1'b1, 1'b1);
    send(4'b0000, 32'h0000_00F0, 32'h0000_00FF);
    expect_single("legal_after", 32'h0000_00F0, 1'b0, 1'b0);

    // Reset in the middle of a shift discards it.
    send(4'b1001, 32'hFFFF_FFFF, 32'd20);
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mid_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    check_eq("mid_rst_quiet", bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute-stage wrapper around the 32-bit ALU function units (AND/OR/ADD/SUB/SLT/XOR/NOR combinational units, iterative shifter). It accepts one operation per valid/ready handshake from decode, drives the operand buses into the function units, and holds the result in an output register until writeback accepts it. Logic and arithmetic ops complete in one cycle. Shifts run one bit per cycle to save area.

## Interface
Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported.
- SHW, 5, shift-amount width, equal to log2(WIDTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented by decode.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  4  alu_op_e opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B. For shifts, b[SHW-1:0] is the shift amount and the upper bits are ignored.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  writeback consumes the result.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result == 0).
- illegal  out  1  registered flag: the opcode is not in alu_op_e.

## Operation
- Accept condition: in_valid & in_ready at a rising edge.
- Opcodes (4-bit encoding):
  - AND=0000, OR=0001, ADD=0010, XOR=0011
  - SUB=0110, SLT=0111
  - SLL=1000, SRL=1001, SRA=1010
  - NOR=1100
  - Any other code is illegal.
- ADD and SUB are modulo 2^32; carry and overflow are discarded.
- SLT is a signed compare: result = {31'b0, $signed(a) < $signed(b)}.
- SRA replicates a[31].
- Illegal opcode: result=0, zero=1, illegal=1, latency one cycle. It never enters SHIFT.
- FSM has two states, IDLE and SHIFT.
  - IDLE: in_ready = !out_valid | out_ready.
    - On accept with a single-cycle op, or a shift with shamt==0: load result, zero and illegal; set out_valid=1; stay in IDLE.
    - On accept with a shift and shamt!=0: load shreg=a and cnt=shamt, go to SHIFT.
    - If the previous result is consumed in the same cycle, clear out_valid.
  - SHIFT: in_ready=0. Each cycle, shreg shifts by one bit in the direction given by the latched op, and cnt decrements.
    - When cnt==1 the final shifted value is written to result, out_valid is set, and the FSM returns to IDLE.
- Consume with no new accept: out_valid&out_ready at an edge with no new accept clears out_valid. result holds its last value.
- result, zero and illegal change only when a new result is written.
- Operands and op are latched at accept. Changes on the inputs after accept have no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, zero=1, illegal=0, state=IDLE, cnt=0, shreg=0.
- Latency, with accept at edge E0:
  - Single-cycle ops: out_valid is high after E0.
  - Shifts with shamt=k>0: out_valid is high after edge E_k.
- Throughput: one single-cycle op per clock while out_ready=1.
- A shift blocks the unit for k cycles.
- Back-pressure: while out_valid=1 and out_ready=0, in_ready=0 and result is stable.
- Consume and accept in the same edge are allowed. The new result overwrites the old one and out_valid stays 1.
- Reset asserted mid-SHIFT: the operation is discarded, all state returns to reset values immediately, and no out_valid pulse follows.
- in_ready is combinational from state, out_valid and out_ready. No other output is combinational from any input.

## Structure
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e
  - WIDTH and SHW localparams
  - typedef enum logic state_e {IDLE, SHIFT}
- Sub-module serial_shifter holds shreg, cnt, the direction and arithmetic fill, and the done pulse. It is instantiated once.
- The single-cycle ops reuse the existing combinational function units, selected by a combinational mux feeding the result register.

## Test plan
- Reset, then OR with a=0x0000_F0F0, b=0x0F0F_0000, out_ready=1 -> one cycle later out_valid=1, result=0x0F0F_F0F0, zero=0.
- SUB a=5, b=5 -> result=0, zero=1. Then SLT a=0xFFFF_FFFF, b=1 -> result=1.
- SRA a=0x8000_0000, b=31 -> in_ready=0 for 31 cycles, then result=0xFFFF_FFFF. SLL with b=0x20 (shamt 0) -> result=a after one cycle.
- Back-pressure: out_ready=0 after ADD 1+2 -> result=3 held for 10 cycles and in_ready=0. Raise out_ready together with in_valid (XOR) -> new result on the next edge, out_valid stays 1.
- op=0100 -> illegal=1, result=0, zero=1, no SHIFT entry.
- rst_n low for one cycle during a SRL with shamt 20 -> out_valid=0, in_ready=1, and no result appears afterwards.
